seg_value_encoder: RTL



---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_digit_decode.sv | 25 ++
 rtl/seg_value_encoder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment value encoder.
// Segment patterns are common-anode (lit segment = 0), bit order {dp,g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int unsigned DP_BIT      = 7;
    localparam int unsigned MAX_DISPLAY = 999;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE
    } state_e;

endpackage

// File: rtl/seg_digit_decode.sv
// One BCD digit to a common-anode segment pattern; dash overrides blank,
// and the decimal point is applied on top of whatever glyph is selected.
module seg_digit_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    input  logic       dash_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (dash_i) begin
            seg_o = SEG_DASH;
        end else if (!blank_i && (bcd_i <= 4'd9)) begin
            seg_o = SEG_DIGIT[bcd_i];
        end
        if (dp_i) begin
            seg_o[DP_BIT] = 1'b0;
        end
    end

endmodule

// File: rtl/seg_value_encoder.sv
// Binary (0..999) to three seven-segment patterns: serial shift-add-3 BCD
// conversion followed by a single encode cycle that updates all digits at once.
module seg_value_encoder
    import seg_pkg::*;
#(
    parameter int unsigned IN_W       = 10,
    parameter bit          LZB        = 1'b1,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_value,
    input  logic [2:0]      in_dp,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [7:0]      seg_data_0,
    output logic [7:0]      seg_data_1,
    output logic [7:0]      seg_data_2,
    output logic            done
);

    localparam int unsigned CNT_W = $clog2(IN_W + 1);
    localparam logic [7:0]  POL   = ACTIVE_LOW ? 8'h00 : 8'hFF;

    state_e            state_q, state_d;
    logic [IN_W-1:0]   value_q, value_d;
    logic [2:0]        dp_q, dp_d;
    logic [11:0]       bcd_q, bcd_d, bcd_adj;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        seg0_q, seg0_d, seg1_q, seg1_d, seg2_q, seg2_d;
    logic              done_q, done_d;
    logic [7:0]        pat0, pat1, pat2;
    logic              blank0, blank1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            value_q <= '0;
            dp_q    <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            seg0_q  <= SEG_BLANK ^ POL;
            seg1_q  <= SEG_BLANK ^ POL;
            seg2_q  <= SEG_BLANK ^ POL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            dp_q    <= dp_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            seg0_q  <= seg0_d;
            seg1_q  <= seg1_d;
            seg2_q  <= seg2_d;
            done_q  <= done_d;
        end
    end

    // Digits >= 5 get +3 before the shift so they carry correctly into the next nibble.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        dp_d    = dp_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        seg0_d  = seg0_q;
        seg1_d  = seg1_q;
        seg2_d  = seg2_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    value_d = in_value;
                    dp_d    = in_dp;
                    bcd_d   = '0;
                    ovf_d   = (32'(in_value) > MAX_DISPLAY);
                    cnt_d   = CNT_W'(IN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d   = (bcd_adj << 1) | 12'(value_q[IN_W-1]);
                value_d = value_q << 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                seg0_d  = pat0 ^ POL;
                seg1_d  = pat1 ^ POL;
                seg2_d  = pat2 ^ POL;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign blank0 = LZB && (bcd_q[11:8] == 4'd0);
    assign blank1 = blank0 && (bcd_q[7:4] == 4'd0);

    seg_digit_decode u_dig0 (
        .bcd_i   (bcd_q[11:8]),
        .blank_i (blank0),
        .dash_i  (ovf_q),
        .dp_i    (dp_q[0]),
        .seg_o   (pat0)
    );

    seg_digit_decode u_dig1 (
        .bcd_i   (bcd_q[7:4]),
        .blank_i (blank1),
        .dash_i  (ovf_q),
        .dp_i    (dp_q[1]),
        .seg_o   (pat1)
    );

    seg_digit_decode u_dig2 (
        .bcd_i   (bcd_q[3:0]),
        .blank_i (1'b0),
        .dash_i  (ovf_q),
        .dp_i    (dp_q[2]),
        .seg_o   (pat2)
    );

    assign in_ready   = (state_q == IDLE);
    assign seg_data_0 = seg0_q;
    assign seg_data_1 = seg1_q;
    assign seg_data_2 = seg2_q;
    assign done       = done_q;

endmodule
